button_debouncer: RTL and testbench

- Consumer end of the clock divider's debounce output.
- Takes the divider's debounceClock level and recovers a one-cycle sample tick in the masterClk domain.
- Samples raw, bouncy vending-machine buttons on that tick; declares a press or release only after STABLE_SAMPLES consecutive agreeing samples.
- Outputs clean levels plus single-cycle press/release pulses for the vending FSM.

---
 rtl/button_debouncer_pkg.sv | 22 ++
 rtl/button_debouncer_channel.sv | 120 ++++++++++++
 rtl/button_debouncer.sv | 62 ++++++
 tb/tb_button_debouncer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Brief    : Shared channel state encoding and default sizing for the
//            vending-machine button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btnState_t;

   localparam int DEFAULT_NUM_BTN        = 5;
   localparam int DEFAULT_STABLE_SAMPLES = 3;
   localparam int DEFAULT_CNT_W          = 4;

endpackage
`default_nettype wire

// File: rtl/button_debouncer_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One button: input synchronizer, sample-qualified debounce FSM,
//            registered level and single-cycle press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
   import button_pkg::*;
#(
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int CNT_W          = DEFAULT_CNT_W
) (
   input  logic masterClk,
   input  logic rstN,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic press,
   output logic releasePulse
);

   localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_SAMPLES);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   logic             r_rawMeta;
   logic             r_rawSync;
   btnState_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;

   assign w_cntNext = r_cnt + C_ONE;

   always_ff @(posedge masterClk or negedge rstN) begin
      if (!rstN) begin
         r_rawMeta <= 1'b0;
         r_rawSync <= 1'b0;
      end else begin
         r_rawMeta <= raw;
         r_rawSync <= r_rawMeta;
      end
   end

   // State only moves on a sample tick; pulses default low every cycle.
   always_ff @(posedge masterClk or negedge rstN) begin
      if (!rstN) begin
         r_state      <= RELEASED;
         r_cnt        <= '0;
         level        <= 1'b0;
         press        <= 1'b0;
         releasePulse <= 1'b0;
      end else begin
         press        <= 1'b0;
         releasePulse <= 1'b0;
         if (tick) begin
            case (r_state)
               RELEASED: begin
                  if (r_rawSync) begin
                     if (C_STABLE == C_ONE) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        level   <= 1'b1;
                        press   <= 1'b1;
                     end else begin
                        r_state <= PRESS_PEND;
                        r_cnt   <= C_ONE;
                     end
                  end
               end
               PRESS_PEND: begin
                  if (!r_rawSync) begin
                     r_state <= RELEASED;
                     r_cnt   <= '0;
                  end else if (w_cntNext == C_STABLE) begin
                     r_state <= PRESSED;
                     r_cnt   <= '0;
                     level   <= 1'b1;
                     press   <= 1'b1;
                  end else begin
                     r_cnt   <= w_cntNext;
                  end
               end
               PRESSED: begin
                  if (!r_rawSync) begin
                     if (C_STABLE == C_ONE) begin
                        r_state      <= RELEASED;
                        r_cnt        <= '0;
                        level        <= 1'b0;
                        releasePulse <= 1'b1;
                     end else begin
                        r_state <= RELEASE_PEND;
                        r_cnt   <= C_ONE;
                     end
                  end
               end
               RELEASE_PEND: begin
                  if (r_rawSync) begin
                     r_state <= PRESSED;
                     r_cnt   <= '0;
                  end else if (w_cntNext == C_STABLE) begin
                     r_state      <= RELEASED;
                     r_cnt        <= '0;
                     level        <= 1'b0;
                     releasePulse <= 1'b1;
                  end else begin
                     r_cnt   <= w_cntNext;
                  end
               end
               default: begin
                  r_state <= RELEASED;
                  r_cnt   <= '0;
                  level   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Recovers a sample tick from the divider's debounce clock and
//            debounces NUM_BTN independent vending-machine buttons with it.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer
   import button_pkg::*;
#(
   parameter int NUM_BTN        = DEFAULT_NUM_BTN,
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int CNT_W          = DEFAULT_CNT_W
) (
   input  logic               masterClk,
   input  logic               rstN,
   input  logic               debounceClock,
   input  logic [NUM_BTN-1:0] btnRaw,
   output logic [NUM_BTN-1:0] btnLevel,
   output logic [NUM_BTN-1:0] btnPress,
   output logic [NUM_BTN-1:0] btnRelease
);

   logic r_dbMeta;
   logic r_dbSync;
   logic r_dbPrev;
   logic w_tick;

   always_ff @(posedge masterClk or negedge rstN) begin
      if (!rstN) begin
         r_dbMeta <= 1'b0;
         r_dbSync <= 1'b0;
         r_dbPrev <= 1'b0;
      end else begin
         r_dbMeta <= debounceClock;
         r_dbSync <= r_dbMeta;
         r_dbPrev <= r_dbSync;
      end
   end

   // One masterClk-wide tick per rising edge of the divider output.
   assign w_tick = r_dbSync & ~r_dbPrev;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_channel
         debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .CNT_W          (CNT_W)
         ) u_channel (
            .masterClk    (masterClk),
            .rstN         (rstN),
            .tick         (w_tick),
            .raw          (btnRaw[gi]),
            .level        (btnLevel[gi]),
            .press        (btnPress[gi]),
            .releasePulse (btnRelease[gi])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed bench for button_debouncer with a per-cycle reference
//            model of consecutive-sample debouncing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

   localparam int NB = 5;
   localparam int SS = 3;

   logic          masterClk     = 1'b0;
   logic          rstN          = 1'b0;
   logic          debounceClock = 1'b0;
   logic [NB-1:0] btnRaw        = '0;
   logic [NB-1:0] btnLevel;
   logic [NB-1:0] btnPress;
   logic [NB-1:0] btnRelease;

   button_debouncer #(
      .NUM_BTN        (NB),
      .STABLE_SAMPLES (SS),
      .CNT_W          (4)
   ) dut (
      .masterClk     (masterClk),
      .rstN          (rstN),
      .debounceClock (debounceClock),
      .btnRaw        (btnRaw),
      .btnLevel      (btnLevel),
      .btnPress      (btnPress),
      .btnRelease    (btnRelease)
   );

   always #5 masterClk = ~masterClk;

   int     compared   = 0;
   int     mismatched = 0;
   longint cyc        = 0;
   int     pressCnt[NB];
   int     relCnt[NB];
   longint lastPressCyc[NB];
   bit     dbRun = 1'b0;

   // Divider stand-in: toggles every 8 masterClk cycles while running.
   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge masterClk);
         if (dbRun) begin
            if (div == 7) begin
               debounceClock = ~debounceClock;
               div = 0;
            end else begin
               div++;
            end
         end
      end
   end

   // Model: a button flips once SS consecutive tick samples disagree with it.
   bit            dH[3];
   logic [NB-1:0] rH0, rH1;
   logic [NB-1:0] mLevel, mPress, mRel;
   int            run[NB];

   initial begin
      for (int i = 0; i < NB; i++) begin
         pressCnt[i] = 0;
         relCnt[i] = 0;
         lastPressCyc[i] = 0;
         run[i] = 0;
      end
      mLevel = '0; mPress = '0; mRel = '0; rH0 = '0; rH1 = '0;
      dH[0] = 0; dH[1] = 0; dH[2] = 0;
   end

   always @(posedge masterClk) begin
      logic [2:0] expV, actV;
      cyc++;
      if (!rstN) begin
         dH[0] = 0; dH[1] = 0; dH[2] = 0;
         rH0 = '0; rH1 = '0;
         mLevel = '0; mPress = '0; mRel = '0;
         for (int i = 0; i < NB; i++) run[i] = 0;
      end else begin
         mPress = '0;
         mRel   = '0;
         if (dH[1] && !dH[2]) begin
            for (int i = 0; i < NB; i++) begin
               if (rH1[i] != mLevel[i]) begin
                  run[i]++;
                  if (run[i] == SS) begin
                     mLevel[i] = rH1[i];
                     if (rH1[i]) mPress[i] = 1'b1;
                     else        mRel[i]   = 1'b1;
                     run[i] = 0;
                  end
               end else begin
                  run[i] = 0;
               end
            end
         end
         dH[2] = dH[1]; dH[1] = dH[0]; dH[0] = debounceClock;
         rH1 = rH0; rH0 = btnRaw;
      end
      #1;
      for (int i = 0; i < NB; i++) begin
         expV = rstN ? {mLevel[i], mPress[i], mRel[i]} : 3'b000;
         actV = {btnLevel[i], btnPress[i], btnRelease[i]};
         compared++;
         if (actV !== expV) begin
            mismatched++;
            $display("FAIL cycle %0d ch%0d {level,press,release}: got %b expected %b",
                     cyc, i, actV, expV);
         end
         if (btnPress[i]) begin
            pressCnt[i]++;
            lastPressCyc[i] = cyc;
         end
         if (btnRelease[i]) relCnt[i]++;
      end
      compared++;
      if ((btnPress & btnRelease) != '0) begin
         mismatched++;
         $display("FAIL cycle %0d press&release overlap: got %b expected 0",
                  cyc, btnPress & btnRelease);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic waitEdge(input bit rising, input int n);
      for (int k = 0; k < n; k++) begin
         bit seen, p;
         seen = 0;
         p = debounceClock;
         for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge masterClk);
            #1;
            if (rising ? (!p && debounceClock) : (p && !debounceClock)) seen = 1;
            p = debounceClock;
         end
         if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL debounceClock edge timeout: got none expected edge");
         end
      end
   endtask

   initial begin
      logic [NB-1:0] lvlSnap;
      int pSnap, rSnap, pNow, rNow;
      bit seq1[5];
      bit seq2[5];
      seq1 = '{1, 0, 1, 1, 1};
      seq2 = '{0, 1, 0, 0, 0};

      // Reset held with all buttons pressed and the divider running.
      rstN = 1'b0;
      btnRaw = '1;
      dbRun = 1'b1;
      repeat (40) @(negedge masterClk);
      chk("reset level", btnLevel, 0);
      chk("reset press count", pressCnt[0] + pressCnt[1] + pressCnt[4], 0);
      waitEdge(0, 1);
      rstN = 1'b1;
      btnRaw = 5'b00001;
      waitEdge(0, 2);
      chk("ch0 press after 2 ticks", pressCnt[0], 0);
      waitEdge(0, 1);
      chk("ch0 press after 3 ticks", pressCnt[0], 1);
      chk("ch0 level after press", btnLevel[0], 1);

      // Bounce on ch1, with an off-tick glitch during a 0 sample.
      for (int k = 0; k < 5; k++) begin
         btnRaw[1] = seq1[k];
         if (!seq1[k]) begin
            repeat (11) @(negedge masterClk);
            btnRaw[1] = 1'b1;
            @(negedge masterClk);
            btnRaw[1] = 1'b0;
         end
         waitEdge(0, 1);
         if (k == 1) chk("ch1 bounce press after 2", pressCnt[1], 0);
         if (k == 3) chk("ch1 bounce press after 4", pressCnt[1], 0);
      end
      chk("ch1 bounce press after 5", pressCnt[1], 1);
      chk("ch1 level pressed", btnLevel[1], 1);

      for (int k = 0; k < 5; k++) begin
         btnRaw[1] = seq2[k];
         waitEdge(0, 1);
         if (k == 3) chk("ch1 release after 4", relCnt[1], 0);
      end
      chk("ch1 release after 5", relCnt[1], 1);
      chk("ch1 level released", btnLevel[1], 0);

      // Release ch0, then press ch0 and ch4 together.
      btnRaw[0] = 1'b0;
      waitEdge(0, 3);
      chk("ch0 release", relCnt[0], 1);
      btnRaw[0] = 1'b1;
      btnRaw[4] = 1'b1;
      waitEdge(0, 3);
      chk("ch0 second press", pressCnt[0], 2);
      chk("ch4 press", pressCnt[4], 1);
      chk("ch0/ch4 same cycle", lastPressCyc[0] - lastPressCyc[4], 0);
      chk("ch2+ch3 quiet", pressCnt[2] + pressCnt[3], 0);
      chk("levels after simultaneous", btnLevel, 5'b10001);

      // Reset in the middle of ch2's press qualification.
      btnRaw[2] = 1'b1;
      waitEdge(0, 2);
      chk("ch2 pending before reset", pressCnt[2], 0);
      @(negedge masterClk);
      rstN = 1'b0;
      repeat (3) @(negedge masterClk);
      chk("level during reset", btnLevel, 0);
      rstN = 1'b1;
      waitEdge(0, 2);
      chk("ch2 no early press after reset", pressCnt[2], 0);
      waitEdge(0, 1);
      chk("ch2 press after reset", pressCnt[2], 1);
      chk("ch0 re-press after reset", pressCnt[0], 3);

      // Stalled divider: inputs churn, nothing may move.
      waitEdge(1, 1);
      dbRun = 1'b0;
      repeat (10) @(negedge masterClk);
      lvlSnap = btnLevel;
      pSnap = 0; rSnap = 0;
      for (int i = 0; i < NB; i++) begin
         pSnap += pressCnt[i];
         rSnap += relCnt[i];
      end
      for (int t = 0; t < 1000; t++) begin
         @(negedge masterClk);
         btnRaw = NB'($urandom);
      end
      @(negedge masterClk);
      pNow = 0; rNow = 0;
      for (int i = 0; i < NB; i++) begin
         pNow += pressCnt[i];
         rNow += relCnt[i];
      end
      chk("stall level hold", btnLevel, lvlSnap);
      chk("stall press count", pNow, pSnap);
      chk("stall release count", rNow, rSnap);

      btnRaw = '0;
      dbRun = 1'b1;
      waitEdge(0, 5);
      chk("all released at end", btnLevel, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
